float_div_seq: RTL

Sequential IEEE-754 single-precision divider for the kNN datapath. It is the inverse companion of the combinational float multiplier and is used for normalisation and scaling steps. Operands are captured on a start handshake. The 24-bit mantissa quotient is produced by a one-bit-per-cycle restoring divider, then normalised and packed into a 32-bit result. Completion is flagged with a one-cycle done pulse.

---
 rtl/float_div_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/float_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring 26-iteration mantissa divide, then normalise and pack.
// Define FLOAT_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module float_div_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {IDLE, SPECIAL, DIV, NORM} state_t;

   state_t        state_q, state_d;
   logic [31:0]   a_q, b_q;
   logic [24:0]   rem_q;
   logic [25:0]   quo_q;
   logic [4:0]    cnt_q;

   logic          accept;
   logic [24:0]   bm;
   logic          rem_ge;
   logic [24:0]   rem_sub;
   logic          load;
   logic [31:0]   res_nxt;
   logic          dbz_nxt;

   logic          sign;
   logic signed [9:0] exp_base, exp_r;
   logic [22:0]   mant, mant_r;
   logic          guard, sticky;

   assign accept  = (state_q == IDLE) && start;
   assign bm      = {2'b01, b_q[22:0]};
   assign rem_ge  = (rem_q >= bm);
   assign rem_sub = rem_ge ? (rem_q - bm) : rem_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; zero detection uses the operands being captured on accept
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (A[30:23] == '0 || B[30:23] == '0) ? SPECIAL : DIV;
         SPECIAL: state_d = IDLE;
         DIV:     if (cnt_q == 5'd25) state_d = NORM;
         NORM:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Normalise, round and pack the quotient from the registered divider state
   always_comb begin
      sign     = a_q[31] ^ b_q[31];
      exp_base = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
               + (quo_q[25] ? 10'sd127 : 10'sd126);
      if (quo_q[25]) begin
         mant   = quo_q[24:2];
         guard  = quo_q[1];
         sticky = quo_q[0] | (rem_q != '0);
      end else begin
         mant   = quo_q[23:1];
         guard  = quo_q[0];
         sticky = (rem_q != '0);
      end
   end

`ifdef FLOAT_DIV_ROUND_EN
   logic [23:0] mant_sum;
   always_comb begin
      mant_sum = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
      mant_r   = mant_sum[22:0];
      exp_r    = exp_base + $signed({9'd0, mant_sum[23]});
   end
`else
   // Truncation: guard and sticky are computed but deliberately discarded
   logic trunc_unused;
   assign trunc_unused = guard ^ sticky;
   always_comb begin
      mant_r = mant;
      exp_r  = exp_base;
   end
`endif

   // Output logic
   always_comb begin
      busy    = (state_q != IDLE);
      load    = 1'b0;
      res_nxt = '0;
      dbz_nxt = 1'b0;
      case (state_q)
         SPECIAL: begin
            load = 1'b1;
            if (b_q[30:23] == '0) begin
               res_nxt = {sign, 8'hFF, 23'h0};
               dbz_nxt = 1'b1;
            end else begin
               res_nxt = {sign, 31'h0};
            end
         end
         NORM: begin
            load = 1'b1;
            if (exp_r >= 10'sd255)     res_nxt = {sign, 8'hFF, 23'h0};
            else if (exp_r <= 10'sd0)  res_nxt = {sign, 31'h0};
            else                       res_nxt = {sign, exp_r[7:0], mant_r};
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         done        <= 1'b0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= load;
         if (load) begin
            result      <= res_nxt;
            div_by_zero <= dbz_nxt;
         end
         if (accept) begin
            a_q   <= A;
            b_q   <= B;
            rem_q <= {2'b01, A[22:0]};
            quo_q <= '0;
            cnt_q <= '0;
         end else if (state_q == DIV) begin
            rem_q <= {rem_sub[23:0], 1'b0};
            quo_q <= {quo_q[24:0], rem_ge};
            cnt_q <= (cnt_q == 5'd25) ? 5'd0 : cnt_q + 5'd1;
         end
      end
   end

endmodule
